// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared types and sizes for the multi-way reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    // Register-file sizes mirror nand_cpu.svh
    localparam int NUM_D_REG = 64;
    localparam int NUM_S_REG = 32;
    localparam int ROB_DEPTH = 16;

    localparam int D_AW   = $clog2(NUM_D_REG);
    localparam int S_AW   = $clog2(NUM_S_REG);
    localparam int ROB_TW = $clog2(ROB_DEPTH);

    typedef logic [ROB_TW-1:0] rob_tag_t;

    typedef struct packed {
        logic            use_rw;
        logic [D_AW-1:0] prev_rw_addr;
        logic            use_rs;
        logic [S_AW-1:0] prev_rs_addr;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_commit_select.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_select
// Description : Picks the oldest contiguous run of occupied+done entries.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_select
    import rob_pkg::*;
#(
    parameter  int DEPTH    = ROB_DEPTH,
    parameter  int COMMIT_W = 2,
    localparam int TW       = $clog2(DEPTH),
    localparam int CW       = TW + 1
) (
    input  logic [TW-1:0]       head,
    input  logic [CW-1:0]       count,
    input  logic [DEPTH-1:0]    occupied,
    input  logic [DEPTH-1:0]    done,
    output logic [COMMIT_W-1:0] commit_mask,
    output logic [CW-1:0]       ncommit
);

    logic          w_run;
    logic [TW-1:0] w_idx;

    // Bounding by count keeps an empty buffer silent even with stale done bits
    always_comb begin
        commit_mask = '0;
        ncommit     = '0;
        w_run       = 1'b1;
        w_idx       = head;
        for (int k = 0; k < COMMIT_W; k++) begin
            w_idx = head + TW'(k);
            if (w_run && (CW'(k) < count) && occupied[w_idx] && done[w_idx]) begin
                commit_mask[k] = 1'b1;
                ncommit        = ncommit + CW'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer_mw.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_mw
// Description : Multi-way ROB: in-order allocate, tagged completion, in-order
//               retire, partial rollback and full flush.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer_mw
    import rob_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int DISPATCH_W = 2,
    parameter  int COMMIT_W   = 2,
    parameter  int CPL_W      = 2,
    localparam int TW         = $clog2(DEPTH),
    localparam int CW         = TW + 1
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [DISPATCH_W-1:0]          disp_valid,
    input  rob_entry_t [DISPATCH_W-1:0]    disp_entry,
    output logic                           disp_ready,
    output logic [DISPATCH_W-1:0][TW-1:0]  disp_tag,
    output logic [CW-1:0]                  free_slots,
    input  logic [CPL_W-1:0]               cpl_valid,
    input  logic [CPL_W-1:0][TW-1:0]       cpl_tag,
    output logic [COMMIT_W-1:0]            commit_valid,
    output rob_entry_t [COMMIT_W-1:0]      commit_entry,
    input  logic                           rollback_valid,
    input  logic [TW-1:0]                  rollback_tag,
    input  logic                           flush
);

    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] DISP_W_CNT = CW'(DISPATCH_W);

    logic [TW-1:0]    head_q, head_d;
    logic [TW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] occupied_q, occupied_d;
    logic [DEPTH-1:0] done_q, done_d;
    rob_entry_t       entries_q [DEPTH];
    rob_entry_t       entries_d [DEPTH];

    logic [CW-1:0]    w_ncommit;
    logic [CW-1:0]    w_ndisp;
    logic [CW-1:0]    w_keep;
    logic [TW-1:0]    w_offs;

    assign free_slots = DEPTH_CNT - count_q;
    assign disp_ready = (free_slots >= DISP_W_CNT);

    generate
        for (genvar i = 0; i < DISPATCH_W; i++) begin : g_disp_tag
            assign disp_tag[i] = tail_q + TW'(i);
        end
        for (genvar k = 0; k < COMMIT_W; k++) begin : g_commit_entry
            assign commit_entry[k] = entries_q[head_q + TW'(k)];
        end
    endgenerate

    rob_commit_select #(
        .DEPTH    (DEPTH),
        .COMMIT_W (COMMIT_W)
    ) u_commit_select (
        .head        (head_q),
        .count       (count_q),
        .occupied    (occupied_q),
        .done        (done_q),
        .commit_mask (commit_valid),
        .ncommit     (w_ncommit)
    );

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        occupied_d = occupied_q;
        done_d     = done_q;
        entries_d  = entries_q;
        w_ndisp    = '0;
        w_keep     = '0;
        w_offs     = '0;

        for (int i = 0; i < DISPATCH_W; i++) begin
            if (disp_ready && disp_valid[i]) begin
                w_ndisp = w_ndisp + CW'(1);
            end
        end

        // Unoccupied targets are ignored; done is idempotent so duplicates are harmless
        for (int p = 0; p < CPL_W; p++) begin
            if (cpl_valid[p] && occupied_q[cpl_tag[p]]) begin
                done_d[cpl_tag[p]] = 1'b1;
            end
        end

        for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_valid[k]) begin
                occupied_d[head_q + TW'(k)] = 1'b0;
                done_d[head_q + TW'(k)]     = 1'b0;
            end
        end
        head_d = head_q + TW'(w_ncommit);

        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            occupied_d = '0;
            done_d     = '0;
        end else if (rollback_valid) begin
            // Survivors span head..rollback_tag; a full buffer rolled back to head-1 keeps DEPTH
            w_keep  = {1'b0, rollback_tag - head_q} + CW'(1);
            tail_d  = rollback_tag + TW'(1);
            count_d = w_keep - w_ncommit;
            for (int i = 0; i < DEPTH; i++) begin
                w_offs = TW'(i) - head_q;
                if ({1'b0, w_offs} >= w_keep) begin
                    occupied_d[i] = 1'b0;
                    done_d[i]     = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (disp_ready && disp_valid[i]) begin
                    entries_d[tail_q + TW'(i)]  = disp_entry[i];
                    occupied_d[tail_q + TW'(i)] = 1'b1;
                    done_d[tail_q + TW'(i)]     = 1'b0;
                end
            end
            tail_d  = tail_q + TW'(w_ndisp);
            count_d = count_q + w_ndisp - w_ncommit;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            occupied_q <= '0;
            done_q     <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            occupied_q <= occupied_d;
            done_q     <= done_d;
        end
    end

    // Payload is only meaningful behind an occupied bit, so it needs no reset
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule
`default_nettype wire
